// File: rtl/instr_issue_unit.sv
// instr_issue_unit: fetch/issue stage. Owns the PC and the IF/ID register,
// runs the instruction-memory handshake, inserts load-use stall bubbles,
// flushes on taken branches and stops fetching on HALT.
// Optional build macro: ISSUE_PERF_CNT_EN adds saturating counters
// cnt_issued and cnt_bubbles.
module instr_issue_unit #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 32,
    parameter int RST_PC  = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               ex_memread,
    input  logic [4:0]         ex_rd,
    output logic               id_valid,
    output logic [4:0]         id_opcode,
    output logic [4:0]         id_rd,
    output logic [4:0]         id_rs,
    output logic [4:0]         id_rt,
    output logic [11:0]        id_imm,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               stall,
    output logic               halted
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]        cnt_issued,
    output logic [31:0]        cnt_bubbles
`endif
);

    typedef enum logic {S_FETCH = 1'b0, S_HALT = 1'b1} state_t;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_CMP  = 5'b01011;
    localparam logic [4:0] OP_MOV  = 5'b10010;
    localparam logic [4:0] OP_BEQ  = 5'b01100;
    localparam logic [4:0] OP_SW   = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11111;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    id_pc_q, id_pc_d;
    logic                 id_valid_q, id_valid_d;

    logic [4:0]           opcode_raw;
    logic                 rt_used;
    logic                 hz;

    assign opcode_raw = instr_q[31:27];
    assign id_rd      = instr_q[26:22];
    assign id_rs      = instr_q[21:17];
    assign id_rt      = instr_q[16:12];
    assign id_imm     = instr_q[11:0];
    assign id_pc      = id_pc_q;
    assign id_valid   = id_valid_q;
    assign imem_addr  = pc_q;
    assign halted     = (state_q == S_HALT);

    // Load-use hazard detection and combinational issue outputs
    always_comb begin
        rt_used   = opcode_raw inside {OP_ADD, OP_XOR, OP_CMP, OP_MOV, OP_BEQ, OP_SW};
        hz        = ex_memread && id_valid_q && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || ((ex_rd == id_rt) && rt_used));
        // A taken branch flushes ID, so the hazard against it is moot.
        stall     = hz && !branch_taken && (state_q == S_FETCH);
        // reset_n gating keeps the request low while reset is held.
        imem_req  = reset_n && (state_q == S_FETCH) && !stall;
        id_opcode = (id_valid_q && !stall) ? opcode_raw : 5'b00000;
    end

    // Next-state: branch flush > stall hold > HALT > capture > bubble
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        if (state_q == S_FETCH) begin
            if (branch_taken) begin
                pc_d       = branch_target;
                id_valid_d = 1'b0;
            end else if (!stall) begin
                if (id_valid_q && (opcode_raw == OP_HALT)) begin
                    state_d    = S_HALT;
                    id_valid_d = 1'b0;
                end else if (imem_ready) begin
                    instr_d    = imem_rdata;
                    id_pc_d    = pc_q;
                    pc_d       = pc_q + ADDR_W'(1);
                    id_valid_d = 1'b1;
                end else begin
                    id_valid_d = 1'b0;
                end
            end
        end
    end

    // State, PC and IF/ID registers; reset abandons any in-flight fetch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            pc_q       <= ADDR_W'(RST_PC);
            instr_q    <= '0;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] cnt_issued_q, cnt_issued_d;
    logic [31:0] cnt_bubbles_q, cnt_bubbles_d;

    // Saturating performance counters
    always_comb begin
        cnt_issued_d  = cnt_issued_q;
        cnt_bubbles_d = cnt_bubbles_q;
        if (id_valid_q && !stall && (opcode_raw != OP_HALT) && (cnt_issued_q != '1))
            cnt_issued_d = cnt_issued_q + 32'd1;
        if ((id_opcode == 5'b00000) && (state_q == S_FETCH) && (cnt_bubbles_q != '1))
            cnt_bubbles_d = cnt_bubbles_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_issued_q  <= '0;
            cnt_bubbles_q <= '0;
        end else begin
            cnt_issued_q  <= cnt_issued_d;
            cnt_bubbles_q <= cnt_bubbles_d;
        end
    end

    assign cnt_issued  = cnt_issued_q;
    assign cnt_bubbles = cnt_bubbles_q;
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed testbench for instr_issue_unit (default build, ISSUE_PERF_CNT_EN undefined).
module tb_instr_issue_unit;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 32;

    localparam logic [4:0] ADD  = 5'b00001;
    localparam logic [4:0] XOR  = 5'b00101;
    localparam logic [4:0] NOP  = 5'b00010;
    localparam logic [4:0] MOVI = 5'b10001;
    localparam logic [4:0] HALT = 5'b11111;

    logic               clk;
    logic               reset_n;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic               ex_memread;
    logic [4:0]         ex_rd;
    logic               id_valid;
    logic [4:0]         id_opcode, id_rd, id_rs, id_rt;
    logic [11:0]        id_imm;
    logic [ADDR_W-1:0]  id_pc;
    logic               stall, halted;

    logic [INSTR_W-1:0] mem [0:(1<<ADDR_W)-1];
    int n_checks = 0;
    int n_fail   = 0;

    instr_issue_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RST_PC(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm),
        .id_pc(id_pc), .stall(stall), .halted(halted)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [11:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = mk(NOP, 5'd0, 5'd0, 5'd0, 12'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with all inputs idle; leaves reset released 1 time unit after an edge.
    task automatic do_reset();
        reset_n = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0;
        branch_target = '0; ex_memread = 1'b0; ex_rd = 5'd0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        fill_mem();
        imem_ready = 1'b1; branch_taken = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        branch_target = '0;
        reset_n = 1'b0;
        #3;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", id_valid); end
        n_checks++; if (id_opcode !== 5'd0) begin n_fail++; $display("FAIL rst_opcode: got %b want 00000", id_opcode); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
        n_checks++; if (imem_addr !== 10'd0) begin n_fail++; $display("FAIL rst_addr: got %0h want 0", imem_addr); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_after: got %b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        fill_mem();
        mem[0] = mk(ADD, 5'd1, 5'd2, 5'd3, 12'h00A);
        mem[1] = mk(ADD, 5'd4, 5'd5, 5'd6, 12'h0B1);
        mem[2] = mk(ADD, 5'd7, 5'd8, 5'd9, 12'hC02);
        do_reset();
        imem_ready = 1'b1;
        tick();
        n_checks++; if (id_opcode !== ADD) begin n_fail++; $display("FAIL seq_op0: got %b want 00001", id_opcode); end
        n_checks++; if (id_pc !== 10'd0) begin n_fail++; $display("FAIL seq_pc0: got %0h want 0", id_pc); end
        n_checks++; if (imem_addr !== 10'd1) begin n_fail++; $display("FAIL seq_addr0: got %0h want 1", imem_addr); end
        n_checks++; if ({id_rd, id_rs, id_rt, id_imm} !== {5'd1, 5'd2, 5'd3, 12'h00A}) begin
            n_fail++; $display("FAIL seq_fields0: got rd%0d rs%0d rt%0d imm%0h want rd1 rs2 rt3 immA", id_rd, id_rs, id_rt, id_imm); end
        tick();
        n_checks++; if (id_opcode !== ADD) begin n_fail++; $display("FAIL seq_op1: got %b want 00001", id_opcode); end
        n_checks++; if (id_pc !== 10'd1) begin n_fail++; $display("FAIL seq_pc1: got %0h want 1", id_pc); end
        n_checks++; if (imem_addr !== 10'd2) begin n_fail++; $display("FAIL seq_addr1: got %0h want 2", imem_addr); end
        n_checks++; if (id_imm !== 12'h0B1) begin n_fail++; $display("FAIL seq_imm1: got %0h want 0B1", id_imm); end
        tick();
        n_checks++; if (id_pc !== 10'd2) begin n_fail++; $display("FAIL seq_pc2: got %0h want 2", id_pc); end
        n_checks++; if (imem_addr !== 10'd3) begin n_fail++; $display("FAIL seq_addr2: got %0h want 3", imem_addr); end
        n_checks++; if (id_rd !== 5'd7) begin n_fail++; $display("FAIL seq_rd2: got %0d want 7", id_rd); end
    endtask

    task automatic test_load_use();
        fill_mem();
        mem[0] = mk(ADD, 5'd5, 5'd3, 5'd4, 12'd0);
        mem[1] = mk(XOR, 5'd6, 5'd7, 5'd8, 12'd0);
        mem[2] = mk(ADD, 5'd1, 5'd9, 5'd10, 12'd0);
        do_reset();
        imem_ready = 1'b1;
        tick();
        ex_memread = 1'b1; ex_rd = 5'd3;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall); end
        n_checks++; if (id_opcode !== 5'd0) begin n_fail++; $display("FAIL lu_bubble: got %b want 00000", id_opcode); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL lu_req: got %b want 0", imem_req); end
        n_checks++; if (id_rd !== 5'd5) begin n_fail++; $display("FAIL lu_rd_hold: got %0d want 5", id_rd); end
        tick();
        ex_memread = 1'b0; ex_rd = 5'd0;
        #1;
        n_checks++; if (imem_addr !== 10'd1) begin n_fail++; $display("FAIL lu_pc_hold: got %0h want 1", imem_addr); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_end: got %b want 0", stall); end
        n_checks++; if (id_opcode !== ADD) begin n_fail++; $display("FAIL lu_resume: got %b want 00001", id_opcode); end
        n_checks++; if (id_pc !== 10'd0) begin n_fail++; $display("FAIL lu_idpc: got %0h want 0", id_pc); end
        tick();
        n_checks++; if (id_opcode !== XOR) begin n_fail++; $display("FAIL lu_next: got %b want 00101", id_opcode); end
        // rt-side hazard: XOR reads rt=8
        ex_memread = 1'b1; ex_rd = 5'd8;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_rt_stall: got %b want 1", stall); end
        tick();
        ex_memread = 1'b0; ex_rd = 5'd0;
        #1;
        n_checks++; if (id_pc !== 10'd1) begin n_fail++; $display("FAIL lu_rt_hold: got %0h want 1", id_pc); end
    endtask

    task automatic test_no_hazard();
        fill_mem();
        mem[0] = mk(ADD, 5'd2, 5'd0, 5'd0, 12'd0);
        mem[1] = mk(MOVI, 5'd4, 5'd1, 5'd3, 12'h055);
        do_reset();
        imem_ready = 1'b1;
        tick();
        ex_memread = 1'b1; ex_rd = 5'd0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL nh_rd0_stall: got %b want 0", stall); end
        n_checks++; if (id_opcode !== ADD) begin n_fail++; $display("FAIL nh_rd0_op: got %b want 00001", id_opcode); end
        tick();
        ex_rd = 5'd3;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL nh_movi_stall: got %b want 0", stall); end
        n_checks++; if (id_opcode !== MOVI) begin n_fail++; $display("FAIL nh_movi_op: got %b want 10001", id_opcode); end
        n_checks++; if (id_pc !== 10'd1) begin n_fail++; $display("FAIL nh_movi_pc: got %0h want 1", id_pc); end
        ex_memread = 1'b0; ex_rd = 5'd0;
    endtask

    task automatic test_branch_flush();
        fill_mem();
        mem[0]    = mk(ADD, 5'd1, 5'd3, 5'd2, 12'd0);
        mem[1]    = mk(ADD, 5'd1, 5'd1, 5'd1, 12'd0);
        mem[10'h20] = mk(XOR, 5'd9, 5'd10, 5'd11, 12'h020);
        do_reset();
        imem_ready = 1'b1;
        tick();
        ex_memread = 1'b1; ex_rd = 5'd3; branch_taken = 1'b1; branch_target = 10'h20;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL br_stall_mask: got %b want 0", stall); end
        tick();
        branch_taken = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush: got %b want 0", id_valid); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL br_stall_next: got %b want 0", stall); end
        n_checks++; if (imem_addr !== 10'h20) begin n_fail++; $display("FAIL br_addr: got %0h want 20", imem_addr); end
        n_checks++; if (id_opcode !== 5'd0) begin n_fail++; $display("FAIL br_op: got %b want 00000", id_opcode); end
        ex_memread = 1'b0; ex_rd = 5'd0;
        tick();
        n_checks++; if (id_pc !== 10'h20) begin n_fail++; $display("FAIL br_idpc: got %0h want 20", id_pc); end
        n_checks++; if (id_opcode !== XOR) begin n_fail++; $display("FAIL br_target_op: got %b want 00101", id_opcode); end
    endtask

    task automatic test_ready_wait();
        fill_mem();
        mem[0] = mk(ADD, 5'd1, 5'd2, 5'd3, 12'd0);
        mem[1] = mk(XOR, 5'd4, 5'd5, 5'd6, 12'd7);
        do_reset();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (imem_addr !== 10'd1) begin n_fail++; $display("FAIL rw_addr%0d: got %0h want 1", k, imem_addr); end
            n_checks++; if (id_opcode !== 5'd0) begin n_fail++; $display("FAIL rw_op%0d: got %b want 00000", k, id_opcode); end
            n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rw_req%0d: got %b want 1", k, imem_req); end
        end
        imem_ready = 1'b1;
        tick();
        n_checks++; if (id_opcode !== XOR) begin n_fail++; $display("FAIL rw_arrive: got %b want 00101", id_opcode); end
        n_checks++; if (id_pc !== 10'd1) begin n_fail++; $display("FAIL rw_idpc: got %0h want 1", id_pc); end
    endtask

    task automatic test_wrap_halt();
        fill_mem();
        mem[10'h3FF] = mk(ADD, 5'd1, 5'd2, 5'd3, 12'd0);
        mem[0]       = mk(HALT, 5'd0, 5'd0, 5'd0, 12'd0);
        mem[1]       = mk(ADD, 5'd4, 5'd5, 5'd6, 12'd0);
        do_reset();
        imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 10'h3FF;
        tick();
        branch_taken = 1'b0;
        #1;
        n_checks++; if (imem_addr !== 10'h3FF) begin n_fail++; $display("FAIL wh_addr3ff: got %0h want 3ff", imem_addr); end
        tick();
        n_checks++; if (id_pc !== 10'h3FF) begin n_fail++; $display("FAIL wh_idpc3ff: got %0h want 3ff", id_pc); end
        n_checks++; if (imem_addr !== 10'd0) begin n_fail++; $display("FAIL wh_wrap: got %0h want 0", imem_addr); end
        tick();
        n_checks++; if (id_opcode !== HALT) begin n_fail++; $display("FAIL wh_halt_id: got %b want 11111", id_opcode); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL wh_not_yet: got %b want 0", halted); end
        tick();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL wh_halted: got %b want 1", halted); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wh_req: got %b want 0", imem_req); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL wh_valid: got %b want 0", id_valid); end
        branch_taken = 1'b1; branch_target = 10'h155;
        tick();
        tick();
        n_checks++; if (imem_addr !== 10'd1) begin n_fail++; $display("FAIL wh_br_ignored: got %0h want 1", imem_addr); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL wh_stay: got %b want 1", halted); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wh_req_stay: got %b want 0", imem_req); end
        branch_taken = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++; if (imem_addr !== 10'd0) begin n_fail++; $display("FAIL wh_rst_pc: got %0h want 0", imem_addr); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL wh_rst_halted: got %b want 0", halted); end
        tick();
        reset_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wh_restart: got %b want 1", imem_req); end
    endtask

    initial begin
        reset_n = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0;
        branch_target = '0; ex_memread = 1'b0; ex_rd = 5'd0;
        test_reset();
        test_sequential();
        test_load_use();
        test_no_hazard();
        test_branch_flush();
        test_ready_wait();
        test_wrap_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_issue_unit.md
Name: instr_issue_unit

Overview:
- Fetch/issue stage that produces the 5-bit opcode and instruction fields consumed by the pipeline control decoder (its producer end).
- Owns the PC and the IF/ID register, and handles the instruction-memory handshake.
- Detects load-use hazards and inserts stall bubbles (opcode 5'b00000, all control signals inactive).
- Flushes on taken branches from EX; stops fetching on HALT.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- INSTR_W, 32, instruction width.
- RST_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch word address (= pc).
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- branch_taken  in  1  EX-stage taken branch (BEQ).
- branch_target  in  ADDR_W  redirect address.
- ex_memread  in  1  EX holds LW.
- ex_rd  in  5  EX destination register.
- id_valid  out  1  IF/ID holds a live instruction.
- id_opcode  out  5  opcode to decoder; 5'b00000 when bubble.
- id_rd, id_rs, id_rt  out  5 each  instr[26:22], [21:17], [16:12].
- id_imm  out  12  instr[11:0].
- id_pc  out  ADDR_W  PC of the ID instruction.
- stall  out  1  load-use stall active.
- halted  out  1  unit in HALT state.

Behaviour:
- Instruction fields: opcode = instr[31:27]. HALT opcode = 5'b11111.
- Reset, asynchronous, on reset_n low:
  - pc = RST_PC; IF/ID cleared; id_valid = 0; state = FETCH; halted = 0.
  - Therefore id_opcode = 0, stall = 0, imem_req = 0 while reset_n is low.
  - Reset asserted mid-fetch abandons the request; no partial capture.
- States:
  - FETCH: imem_req = 1.
  - HALT: imem_req = 0; halted = 1; exit only by reset.
- Hazard:
  - hz = ex_memread & id_valid & (ex_rd != 0) & (ex_rd == id_rs | (ex_rd == id_rt & id_opcode_raw in {ADD 00001, XOR 00101, CMP 01011, MOV 10010, BEQ 01100, SW 01111})).
  - stall = hz & ~branch_taken.
- Per-edge priority in FETCH:
  1. branch_taken:
     - pc <= branch_target; id_valid <= 0 (flush).
     - Any imem_rdata accepted this cycle is discarded; stall is ignored.
  2. stall:
     - pc and IF/ID hold; imem_req = 0; ready is ignored.
     - id_opcode = 5'b00000 combinationally while stall = 1.
     - Other id_* outputs hold their values.
  3. id_valid & id_opcode_raw == HALT:
     - Next state HALT; id_valid <= 0; no further requests.
  4. imem_ready:
     - IF/ID <= imem_rdata; id_pc <= pc; pc <= pc + 1 (wraps modulo 2^ADDR_W); id_valid <= 1.
  5. Otherwise: id_valid <= 0 (bubble); pc holds; imem_req stays 1.
- Outputs:
  - id_opcode = id_valid & ~stall ? opcode_raw : 5'b00000.
- Timing:
  - Latency: ready at edge N gives the instruction on id_* after edge N; 1 instruction/cycle at best.
  - Stall lasts exactly while hz holds, normally 1 cycle.
- In HALT: branch_taken, imem_ready and ex_* are ignored.

Optional Feature:
- Macro ISSUE_PERF_CNT_EN.
- With the macro defined, adds:
  - cnt_issued, 32-bit output: counts cycles with id_valid & ~stall & non-HALT.
  - cnt_bubbles, 32-bit output: counts cycles where id_opcode = 0 and state = FETCH (includes stall, flush and ready-wait bubbles).
  - Both counters reset to 0 and saturate at 2^32-1.
- Without the macro: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then ready held high; imem returns ADD (0x08000000 | fields) at addr 0,1,2.
  - id_opcode = 00001 on consecutive cycles.
  - id_pc = 0,1,2; imem_addr = 1,2,3.
- LW r3 in EX (ex_memread = 1, ex_rd = 3) while ID holds ADD rs = 3:
  - stall = 1 for 1 cycle; id_opcode = 00000; imem_req = 0; pc unchanged.
  - Next cycle id_opcode = 00001.
- Same hazard with ex_rd = 0, or ID = MOVI with rt = 3:
  - stall = 0; no bubble.
- branch_taken = 1, target = 0x20, asserted in the same cycle as imem_ready and a hazard:
  - id_valid = 0 and stall = 0 next cycle; imem_addr = 0x20.
  - Next captured id_pc = 0x20.
- imem_ready low for 3 cycles:
  - imem_addr stable, id_opcode = 0 for 3 cycles, then the instruction appears.
- pc = 0x3FF fetch, then HALT at 0x000:
  - After the 0x3FF fetch, pc wraps to 0.
  - HALT in ID: halted = 1 next edge; imem_req = 0 thereafter.
  - branch_taken is ignored; reset_n low returns pc = 0 and halted = 0.
